// File: rtl/serv_rf_pkg.sv
// Shared definitions for the SERV register-file SRAM slice.
//   rf_depth(width, csr_regs) : number of SRAM words that hold 32 GPRs plus the CSRs.
//   rf_aw(width, csr_regs)    : address width needed for rf_depth words.
//   ST_CLEAR / ST_RUN         : encodings of the single sequencer state bit.
package serv_rf_pkg;

  localparam logic ST_CLEAR = 1'b1;
  localparam logic ST_RUN   = 1'b0;

  typedef enum logic {
    S_RUN   = ST_RUN,
    S_CLEAR = ST_CLEAR
  } rf_state_e;

  function automatic int rf_depth(input int width, input int csr_regs);
    return 32 * (32 + csr_regs) / width;
  endfunction

  function automatic int rf_aw(input int width, input int csr_regs);
    return $clog2(rf_depth(width, csr_regs));
  endfunction

endpackage

// File: rtl/serv_rf_ram_array.sv
// Plain 1R1W synchronous array, read-first, one cycle read latency.
// The read register holds its value when i_ren is low and is forced to zero by i_rclr.
// Ports:
//   i_clk            clock
//   i_wen/i_waddr/i_wdata   write port
//   i_ren/i_raddr    read port
//   i_rclr           synchronous clear of the read register (wins over i_ren)
//   o_rdata          registered read data
module serv_rf_ram_array #(
  parameter int dw    = 8,
  parameter int depth = 144,
  parameter int aw    = 8
) (
  input  logic          i_clk,
  input  logic          i_wen,
  input  logic [aw-1:0] i_waddr,
  input  logic [dw-1:0] i_wdata,
  input  logic          i_ren,
  input  logic [aw-1:0] i_raddr,
  input  logic          i_rclr,
  output logic [dw-1:0] o_rdata
);

  logic [dw-1:0] mem [0:depth-1];

  always_ff @(posedge i_clk) begin
    if (i_wen) mem[i_waddr] <= i_wdata;
  end

  // Nonblocking read of mem in the same edge as the write gives read-first.
  always_ff @(posedge i_clk) begin
    if (i_rclr)     o_rdata <= '0;
    else if (i_ren) o_rdata <= mem[i_raddr];
  end

endmodule

// File: rtl/serv_rf_ram_clr.sv
// Register-file SRAM behind the SERV serial-to-SRAM adapter. After reset it zeroes
// every word (o_busy high meanwhile) so all GPRs and CSRs read 0; then it serves the
// adapter's write/read bus with 1-cycle read latency and hold-on-idle read data.
// Optional macro SERV_RF_RAM_PARITY_EN adds an even-parity bit per word and drives
// o_perr; without it o_perr is tied to 0.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_waddr/i_wdata/i_wen   write port (ignored while clearing, dropped if out of range)
//   i_raddr/i_ren           read port (ignored while clearing, out of range reads 0)
//   o_rdata                 read data, valid the cycle after i_ren
//   o_busy                  clear sequence in progress
//   o_perr                  parity error on the presented read data
//
// state   | meaning
// --------+-------------------------------------------------
// S_CLEAR | writing zero to mem[clr_cnt], one word per cycle
// S_RUN   | serving the external read/write bus
module serv_rf_ram_clr
  import serv_rf_pkg::*;
#(
  parameter int width      = 8,
  parameter int csr_regs   = 4,
  parameter int init_clear = 1,
  parameter int depth      = rf_depth(width, csr_regs),
  parameter int aw         = rf_aw(width, csr_regs)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [aw-1:0]    i_waddr,
  input  logic [width-1:0] i_wdata,
  input  logic             i_wen,
  input  logic [aw-1:0]    i_raddr,
  input  logic             i_ren,
  output logic [width-1:0] o_rdata,
  output logic             o_busy,
  output logic             o_perr
);

`ifdef SERV_RF_RAM_PARITY_EN
  localparam int ram_w = width + 1;
`else
  localparam int ram_w = width;
`endif

  localparam logic [aw-1:0] last_addr = aw'(depth - 1);
  localparam logic [aw:0]   depth_ext = (aw + 1)'(depth);

  rf_state_e     state;
  logic [aw-1:0] clr_cnt;
  logic          clearing;
  logic          waddr_ok;
  logic          raddr_ok;
  logic          arr_wen;
  logic [aw-1:0] arr_waddr;
  logic [ram_w-1:0] arr_wdata;
  logic          arr_ren;
  logic          arr_rclr;
  logic [ram_w-1:0] arr_rdata;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= (init_clear != 0) ? S_CLEAR : S_RUN;
      o_busy  <= (init_clear != 0);
      clr_cnt <= '0;
    end else if (state == S_CLEAR) begin
      if (clr_cnt == last_addr) begin
        state  <= S_RUN;
        o_busy <= 1'b0;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  assign clearing = (state == S_CLEAR);
  assign waddr_ok = ({1'b0, i_waddr} < depth_ext);
  assign raddr_ok = ({1'b0, i_raddr} < depth_ext);

  // Clear owns the write port; reset blocks all array writes.
  assign arr_wen   = !i_rst && (clearing || (i_wen && waddr_ok));
  assign arr_waddr = clearing ? clr_cnt : i_waddr;
`ifdef SERV_RF_RAM_PARITY_EN
  assign arr_wdata = clearing ? '0 : {^i_wdata, i_wdata};
`else
  assign arr_wdata = clearing ? '0 : i_wdata;
`endif

  // Out of range reads load zero, so both data and parity check come out clean.
  assign arr_ren  = !i_rst && !clearing && i_ren && raddr_ok;
  assign arr_rclr = i_rst || clearing || (i_ren && !raddr_ok);

  serv_rf_ram_array #(
    .dw    (ram_w),
    .depth (depth),
    .aw    (aw)
  ) u_array (
    .i_clk   (i_clk),
    .i_wen   (arr_wen),
    .i_waddr (arr_waddr),
    .i_wdata (arr_wdata),
    .i_ren   (arr_ren),
    .i_raddr (i_raddr),
    .i_rclr  (arr_rclr),
    .o_rdata (arr_rdata)
  );

  assign o_rdata = arr_rdata[width-1:0];

`ifdef SERV_RF_RAM_PARITY_EN
  // Decoded from the registered word, so it updates and holds exactly like o_rdata.
  assign o_perr = (^arr_rdata[width-1:0]) ^ arr_rdata[width];
`else
  assign o_perr = 1'b0;
`endif

endmodule
